// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/data widths
// and the active-low hex-to-segment glyph table.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  // {g,f,e,d,c,b,a}, active low, index = nibble
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110,
    7'b0001110
  };

  function automatic logic [6:0] hex_seg(
    input logic [3:0] nib
  );
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button synchroniser + debouncer. The level can
// only rise once the button was seen released.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic armed;
  logic [CW-1:0] cnt;

  // Sync flops reset to "pressed" so a button held
  // through reset never arms the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Arm after a stable release, then debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else if (!armed) begin
      if (s2) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        armed <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_viewer.sv
// Data-memory viewer: buttons step the address,
// 4-digit hex display. Option: DMEM_VIEWER_AUTOSCAN_EN.
module dmem_viewer
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000,
  parameter int AUTO_CYCLES     = 100000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [ADDR_W-1:0] useraddr,
  input  logic [DATA_W-1:0] userdout,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic [ADDR_W-1:0] led
);

  if (DEBOUNCE_CYCLES < 1 || SCAN_CYCLES < 1 ||
      AUTO_CYCLES < 1) begin : g_bad_param
    $error("dmem_viewer: cycle counts must be >= 1");
  end

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam logic [SW-1:0] SLAST =
    SW'(SCAN_CYCLES - 1);

  logic lvl_next;
  logic lvl_prev;
  logic lvl_next_q;
  logic lvl_prev_q;
  logic step_next;
  logic step_prev;
  logic [DATA_W-1:0] view_data;
  logic [SW-1:0] scan_cnt;
  logic [1:0] idx;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .level(lvl_next)
  );

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_prev (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_prev),
    .level(lvl_prev)
  );

  assign step_next = lvl_next & ~lvl_next_q;
  assign step_prev = lvl_prev & ~lvl_prev_q;
  assign led       = useraddr;

  // Delayed levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_next_q <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      lvl_next_q <= lvl_next;
      lvl_prev_q <= lvl_prev;
    end
  end

`ifdef DMEM_VIEWER_AUTOSCAN_EN
  localparam int AW = $clog2(AUTO_CYCLES + 1);
  localparam logic [AW-1:0] ALAST =
    AW'(AUTO_CYCLES - 1);

  logic [AW-1:0] auto_cnt;

  // Buttons step the address; idle timer auto-advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      useraddr <= '0;
      auto_cnt <= '0;
    end else if (step_next | step_prev) begin
      auto_cnt <= '0;
      unique case (1'b1)
        step_next & ~step_prev:
          useraddr <= useraddr + 1'b1;
        step_prev & ~step_next:
          useraddr <= useraddr - 1'b1;
        default: ;
      endcase
    end else if (auto_cnt == ALAST) begin
      auto_cnt <= '0;
      useraddr <= useraddr + 1'b1;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  // Buttons step the address; simultaneous = hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      useraddr <= '0;
    end else begin
      unique case (1'b1)
        step_next & ~step_prev:
          useraddr <= useraddr + 1'b1;
        step_prev & ~step_next:
          useraddr <= useraddr - 1'b1;
        default: ;
      endcase
    end
  end
`endif

  // One-cycle registered copy of the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      view_data <= '0;
    end else begin
      view_data <= userdout;
    end
  end

  // Digit scan timer and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SLAST) begin
      scan_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Registered digit enable and glyph, same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= hex_seg(view_data[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: doc/dmem_viewer.md
DMEM_VIEWER -- requirements
Module: dmem_viewer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter SCAN_CYCLES, default 100000, the number of cycles each display digit stays enabled.
REQ-003 SHALL have parameter AUTO_CYCLES, default 100000000, the auto-advance period in cycles; used only when DMEM_VIEWER_AUTOSCAN_EN is defined.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port btn_next, input, 1, the raw asynchronous "next address" button.
REQ-007 SHALL have port btn_prev, input, 1, the raw asynchronous "previous address" button.
REQ-008 SHALL have port useraddr, output, 5, the data-memory user read address.
REQ-009 SHALL have port userdout, input, 16, the combinational data-memory user read data.
REQ-010 SHALL have port seg, output, 7, the active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an, output, 4, the active-low digit enables; an[0] is the rightmost digit.
REQ-012 SHALL have port led, output, 5, which mirrors useraddr.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser, then a debouncer that updates its output only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 SHALL generate a one-cycle step pulse on each 0->1 transition of a debounced button.
REQ-015 SHALL increment useraddr on a next pulse, wrapping 31->0, and decrement it on a prev pulse, wrapping 0->31.
REQ-016 SHALL leave useraddr unchanged when next and prev pulses occur in the same cycle.
REQ-017 SHALL register userdout into view_data every cycle, giving a 1-cycle latency; a CPU write to the viewed word SHALL appear in view_data within 2 cycles.
REQ-018 SHALL step a 2-bit digit index 0->1->2->3->0, advancing once every SCAN_CYCLES cycles.
REQ-019 SHALL enable exactly one an bit (an = ~(1<<idx)) when out of reset.
REQ-020 SHALL drive seg from the hex decode of view_data[4*idx+3:4*idx], with registered seg/an updated in the same cycle.
REQ-021 SHALL produce the following hex glyph patterns on seg (active-low): 0=1000000, 1=1111001, ..., A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-022 SHALL, while rst_n=0, hold useraddr=0, an=4'b1111, seg=7'b1111111, view_data=0, all counters=0 and debounced levels=0.
REQ-023 SHALL drive an=4'b1110 on the first clock edge after rst_n deasserts.
REQ-024 SHALL discard a button held through reset; a held button SHALL produce a step only after release and a new press.
REQ-025 SHALL abort any in-progress debounce count on reset mid-operation.

Configuration
REQ-026 SHALL, when DMEM_VIEWER_AUTOSCAN_EN is defined, increment useraddr with wrap every AUTO_CYCLES cycles, and any step pulse SHALL clear the auto timer.
REQ-027 SHALL, when DMEM_VIEWER_AUTOSCAN_EN is undefined, change useraddr only via button pulses, with no auto-timer logic synthesised.

Structure
REQ-028 SHALL take ADDR_W=5, DATA_W=16 and the 16-entry hex-to-segment constant table from the shared package cpu_pkg.
REQ-029 SHALL implement the synchroniser plus debouncer as sub-module debouncer, with parameter DEBOUNCE_CYCLES, instantiated twice.

Verification (bench uses DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, AUTO_CYCLES=20)
REQ-030 SHALL check reset: rst_n low for 5 cycles -> an=1111, seg=1111111, useraddr=0; first edge after release -> an=1110.
REQ-031 SHALL check debounce: btn_next glitch high for 2 cycles -> useraddr stays 0; held high for 10 cycles -> useraddr=1 exactly once.
REQ-032 SHALL check wrap: at useraddr=0, prev press -> 31; then next press -> 0.
REQ-033 SHALL check simultaneous presses: next and prev pressed on the same cycle, held 10 cycles -> useraddr unchanged.
REQ-034 SHALL check display: userdout=16'hA3C1 -> over 12 cycles an cycles 1110,1101,1011,0111 with seg=1111001,1000110,0110000,0001000.
REQ-035 SHALL check autoscan: with DMEM_VIEWER_AUTOSCAN_EN and no presses, useraddr goes 0->1 at cycle 20 and 1->2 at cycle 40; without the macro, useraddr=0 after 100 cycles.
